// File: rtl/GNN_pkg.sv
// Shared GNN accelerator definitions: global sizing defaults and the
// state type of the vertex fire sequencer.
package GNN_pkg;

  localparam int Max_FV_num  = 16;
  localparam int Mult_per_PE = 2;
  localparam int Num_Edge_PE = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CMPL,
    WAIT_BUF
  } vfs_state_t;

endpackage

// File: rtl/vertex_fire_sequencer.sv
// Walks the Vertex RS across a feature vector in MULT_PER_PE-wide chunks after a fire,
// paced by PE back-pressure, then pulses complete and waits for the Vertex buffer to drain.
module vertex_fire_sequencer
  import GNN_pkg::*;
#(
  parameter int MAX_FV_NUM  = Max_FV_num,
  parameter int MULT_PER_PE = Mult_per_PE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fire,
  input  logic [$clog2(MAX_FV_NUM):0]   fv_num,
  input  logic                          pe_ready,
  input  logic                          Vertex_buf_idle,
  output logic [$clog2(MAX_FV_NUM)-1:0] start_idx,
  output logic                          pe_valid,
  output logic                          last_chunk,
  output logic                          complete,
  output logic                          busy,
  output logic                          seq_err
);

  localparam int FW = $clog2(MAX_FV_NUM) + 1;
  localparam int IW = FW - 1;
  localparam logic [FW-1:0] MULT_W     = FW'(MULT_PER_PE);
  localparam logic [FW-1:0] MAX_W      = FW'(MAX_FV_NUM);
  localparam logic [FW-1:0] ROUND_ADD  = FW'(MULT_PER_PE - 1);
  localparam logic [FW-1:0] ROUND_MASK = ~ROUND_ADD;

  vfs_state_t    state_q, state_d;
  logic [IW-1:0] start_idx_q, start_idx_d;
  logic [FW-1:0] fv_eff_q, fv_eff_d;
  logic          pe_valid_q, pe_valid_d;
  logic          last_chunk_q, last_chunk_d;
  logic          seq_err_q, seq_err_d;

  logic [FW-1:0] next_sum;
  logic [FW-1:0] fv_round;
  logic          issue;
  logic          is_last;

  always_comb begin
    // The sum is one bit wider than start_idx so the last-chunk compare never wraps.
    next_sum = {1'b0, start_idx_q} + MULT_W;
    fv_round = (fv_num + ROUND_ADD) & ROUND_MASK;
    issue    = (state_q == ISSUE) && pe_ready;
    is_last  = (next_sum >= fv_eff_q);

    state_d      = state_q;
    start_idx_d  = start_idx_q;
    fv_eff_d     = fv_eff_q;
    pe_valid_d   = issue;
    last_chunk_d = issue && is_last;
    seq_err_d    = seq_err_q;

    if (fire && (state_q != IDLE)) begin
      seq_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        start_idx_d = '0;
        if (fire) begin
          state_d = ISSUE;
          if (fv_num == '0) begin
            fv_eff_d  = MULT_W;
            seq_err_d = 1'b1;
          end else if (fv_num > MAX_W) begin
            fv_eff_d  = MAX_W;
            seq_err_d = 1'b1;
          end else begin
            fv_eff_d = fv_round;
            if (fv_round != fv_num) begin
              seq_err_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          if (is_last) begin
            state_d = DRAIN;
          end else begin
            start_idx_d = next_sum[IW-1:0];
          end
        end
      end
      DRAIN: begin
        state_d = CMPL;
      end
      CMPL: begin
        state_d     = WAIT_BUF;
        start_idx_d = '0;
      end
      WAIT_BUF: begin
        start_idx_d = '0;
        if (Vertex_buf_idle) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        start_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_idx_q  <= '0;
      fv_eff_q     <= '0;
      pe_valid_q   <= 1'b0;
      last_chunk_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_idx_q  <= start_idx_d;
      fv_eff_q     <= fv_eff_d;
      pe_valid_q   <= pe_valid_d;
      last_chunk_q <= last_chunk_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign start_idx  = start_idx_q;
  assign pe_valid   = pe_valid_q;
  assign last_chunk = last_chunk_q;
  assign complete   = (state_q == CMPL);
  assign busy       = (state_q != IDLE);
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_vertex_fire_sequencer.sv
// Self-checking bench for vertex_fire_sequencer: table-driven batches, an async
// reset sequence and randomized batches checked against a chunk-count model.
module tb_vertex_fire_sequencer;

  localparam int MAXF = 16;
  localparam int M    = 2;
  localparam int FW   = $clog2(MAXF) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          fire;
  logic [FW-1:0] fv_num;
  logic          pe_ready;
  logic          Vertex_buf_idle;
  logic [FW-2:0] start_idx;
  logic          pe_valid;
  logic          last_chunk;
  logic          complete;
  logic          busy;
  logic          seq_err;

  int total = 0;
  int bad   = 0;
  bit err_exp;

  typedef struct {
    int          fv;
    logic [15:0] pat;
    int          pat_len;
    int          inject_at;
    int          idle_delay;
    bit          fire_exit;
    int          exp_valid;
    int          exp_last;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  vertex_fire_sequencer #(
    .MAX_FV_NUM (MAXF),
    .MULT_PER_PE(M)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fire           (fire),
    .fv_num         (fv_num),
    .pe_ready       (pe_ready),
    .Vertex_buf_idle(Vertex_buf_idle),
    .start_idx      (start_idx),
    .pe_valid       (pe_valid),
    .last_chunk     (last_chunk),
    .complete       (complete),
    .busy           (busy),
    .seq_err        (seq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Chunk count from the feature-count rules: zero means one chunk, large counts
  // clamp to the maximum, anything else rounds up to whole chunks.
  function automatic int chunks_for(input int f);
    int eff;
    if (f == 0) eff = M;
    else if (f > MAXF) eff = MAXF;
    else eff = ((f + M - 1) / M) * M;
    return eff / M;
  endfunction

  function automatic bit illegal(input int f);
    return (f == 0) || (f > MAXF) || ((f % M) != 0);
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle(input string tag, input int b, input int idx,
                             input int v, input int l, input int c);
    check_output({tag, ".busy"}, int'(busy), b);
    if (idx >= 0) check_output({tag, ".start_idx"}, int'(start_idx), idx);
    check_output({tag, ".pe_valid"}, int'(pe_valid), v);
    check_output({tag, ".last_chunk"}, int'(last_chunk), l);
    check_output({tag, ".complete"}, int'(complete), c);
    check_output({tag, ".seq_err"}, int'(seq_err), int'(err_exp));
  endtask

  // Runs one batch from IDLE back to IDLE; called and returning on a falling edge.
  task automatic apply_stimulus(input int f, input logic [15:0] pat, input int pat_len,
                                input bit rnd, input int inject_at, input int idle_delay,
                                input bit fire_exit, output int n_valid, output int last_idx);
    int n;
    int k;
    int cyc;
    bit prev_issue;
    bit prev_last;
    bit rdy;
    n          = chunks_for(f);
    k          = 0;
    cyc        = 0;
    prev_issue = 1'b0;
    prev_last  = 1'b0;
    n_valid    = 0;
    last_idx   = -1;

    check_cycle("idle", 0, 0, 0, 0, 0);
    fire            = 1'b1;
    fv_num          = FW'(f);
    pe_ready        = 1'b0;
    Vertex_buf_idle = 1'b0;
    if (illegal(f)) err_exp = 1'b1;
    @(negedge clk);

    while (k < n && cyc < 200) begin
      check_cycle("issue", 1, k * M, int'(prev_issue), int'(prev_issue & prev_last), 0);
      n_valid += int'(pe_valid);
      if (cyc < pat_len) rdy = pat[cyc];
      else if (rnd) rdy = ($urandom_range(0, 2) != 0);
      else rdy = 1'b1;
      fire     = (cyc == inject_at);
      fv_num   = fire ? FW'(1) : FW'(f);
      pe_ready = rdy;
      if (fire) err_exp = 1'b1;
      prev_issue = rdy;
      prev_last  = rdy && (k == n - 1);
      if (rdy) begin
        last_idx = int'(start_idx);
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    if (k < n) check_output("issue_timeout", k, n);

    fire     = 1'b0;
    pe_ready = 1'b0;
    check_cycle("drain", 1, -1, 1, 1, 0);
    n_valid += int'(pe_valid);
    @(negedge clk);
    check_cycle("cmpl", 1, -1, 0, 0, 1);
    n_valid += int'(pe_valid);
    @(negedge clk);
    repeat (idle_delay) begin
      check_cycle("wait", 1, 0, 0, 0, 0);
      @(negedge clk);
    end
    check_cycle("wait_last", 1, 0, 0, 0, 0);
    Vertex_buf_idle = 1'b1;
    fire            = fire_exit;
    fv_num          = FW'(4);
    if (fire_exit) err_exp = 1'b1;
    @(negedge clk);
    Vertex_buf_idle = 1'b0;
    fire            = 1'b0;
    check_cycle("exit", 0, 0, 0, 0, 0);
  endtask

  initial begin
    int nv;
    int li;
    int f;
    int n;

    vecs[0] = '{8,  16'h0000, 0, -1, 5, 1'b0, 4, 6,  1'b0};
    vecs[1] = '{6,  16'h0019, 5, -1, 1, 1'b0, 3, 4,  1'b0};
    vecs[2] = '{16, 16'h0000, 0, -1, 0, 1'b0, 8, 14, 1'b0};
    vecs[3] = '{8,  16'h0000, 0,  1, 2, 1'b0, 4, 6,  1'b1};
    vecs[4] = '{0,  16'h0000, 0, -1, 1, 1'b0, 1, 0,  1'b1};
    vecs[5] = '{20, 16'h0000, 0, -1, 0, 1'b1, 8, 14, 1'b1};
    vecs[6] = '{5,  16'h0000, 0, -1, 2, 1'b0, 3, 4,  1'b1};

    reset           = 1'b1;
    fire            = 1'b0;
    fv_num          = '0;
    pe_ready        = 1'b0;
    Vertex_buf_idle = 1'b0;
    err_exp         = 1'b0;
    @(negedge clk);
    check_cycle("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].fv, vecs[i].pat, vecs[i].pat_len, 1'b0, vecs[i].inject_at,
                     vecs[i].idle_delay, vecs[i].fire_exit, nv, li);
      check_output($sformatf("vec%0d.valid_count", i), nv, vecs[i].exp_valid);
      check_output($sformatf("vec%0d.last_idx", i), li, vecs[i].exp_last);
      check_output($sformatf("vec%0d.seq_err", i), int'(seq_err), int'(vecs[i].exp_err));
    end

    // Async reset while start_idx is 4, asserted between clock edges.
    fire     = 1'b1;
    fv_num   = FW'(8);
    pe_ready = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_mid.start_idx_before", int'(start_idx), 4);
    #2 reset = 1'b1;
    #1;
    err_exp = 1'b0;
    check_cycle("rst_mid", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset    = 1'b0;
    pe_ready = 1'b0;
    apply_stimulus(4, 16'h0000, 0, 1'b0, -1, 0, 1'b0, nv, li);
    check_output("after_rst.valid_count", nv, 2);
    check_output("after_rst.last_idx", li, 2);

    for (int r = 0; r < 30; r++) begin
      f = int'($urandom_range(0, 31));
      n = chunks_for(f);
      apply_stimulus(f, 16'h0000, 0, 1'b1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                     int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), nv, li);
      check_output($sformatf("rand%0d.valid_count", r), nv, n);
      check_output($sformatf("rand%0d.last_idx", r), li, (n - 1) * M);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vertex_fire_sequencer.md
# vertex_fire_sequencer

Controller that sequences the Vertex reservation station (RS) into the Vertex PE array once the RS has filled and fired. It walks `start_idx` across a vertex's feature vector in `MULT_PER_PE`-wide chunks, paced by PE back-pressure. It then signals `complete` and holds off the next batch until the Vertex buffer reports idle. It sits between the Vertex RS (which consumes `start_idx` and `complete` and produces `fire`) and the Vertex PE array and Vertex buffer.

## Interface
Parameters:
- `MAX_FV_NUM`, 16: maximum feature values per vertex. Power of two.
- `MULT_PER_PE`, 2: feature values consumed per PE per chunk. Power of two, less than or equal to `MAX_FV_NUM`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `fire`  in  1  single-cycle pulse from the RS: all RS entries are full.
- `fv_num`  in  clog2(MAX_FV_NUM)+1  feature values per vertex. Latched on an accepted `fire`.
- `pe_ready`  in  1  Vertex PE array can accept a chunk this cycle.
- `Vertex_buf_idle`  in  1  Vertex buffer has drained.
- `start_idx`  out  clog2(MAX_FV_NUM)  index of the first feature value of the current chunk. Drives the RS.
- `pe_valid`  out  1  RS output data is a valid chunk this cycle. Registered.
- `last_chunk`  out  1  qualifies `pe_valid`: this is the final chunk.
- `complete`  out  1  single-cycle pulse to the RS: all chunks have been delivered.
- `busy`  out  1  high whenever the state is not IDLE.
- `seq_err`  out  1  sticky error flag, cleared only by `reset`.

## Operation
States:
- **IDLE**
  - `start_idx` = 0.
  - On `fire`: latch `fv_eff` and go to ISSUE.
- **ISSUE**
  - Present `start_idx`.
  - If `pe_ready` = 1, the chunk is issued:
    - If `start_idx + MULT_PER_PE >= fv_eff`, go to DRAIN.
    - Otherwise `start_idx += MULT_PER_PE` and stay in ISSUE.
  - If `pe_ready` = 0, hold `start_idx` and issue nothing.
- **DRAIN**
  - One cycle; `pe_valid` for the last chunk is visible.
  - Go to CMPL.
- **CMPL**
  - `complete` = 1 for exactly one cycle.
  - Go to WAIT_BUF.
- **WAIT_BUF**
  - `start_idx` = 0.
  - Leave to IDLE when `Vertex_buf_idle` = 1.

Effective feature count `fv_eff`:
- `fv_num` = 0: `fv_eff` = `MULT_PER_PE` (one chunk) and `seq_err` is set.
- `fv_num` > `MAX_FV_NUM`: clamp to `MAX_FV_NUM` and set `seq_err`.
- `fv_num` not a multiple of `MULT_PER_PE`: round up to the next multiple and set `seq_err`.

Other error and edge rules:
- `fire` while not in IDLE is ignored and sets `seq_err`.
- The `start_idx` sum is computed at clog2(MAX_FV_NUM)+1 bits, so it never wraps. `start_idx` never exceeds `MAX_FV_NUM - MULT_PER_PE`.
- `fire` asserted in the same cycle the FSM moves WAIT_BUF to IDLE is ignored. It counts as not-IDLE, so `seq_err` is set.
- `reset` asserted mid-batch returns the FSM to IDLE immediately. Every output goes to 0 and the latched `fv_eff` is cleared.

## Timing
- Reset values: `start_idx` = 0, `pe_valid` = 0, `last_chunk` = 0, `complete` = 0, `busy` = 0, `seq_err` = 0. The FSM is in IDLE.
- Issue-to-valid latency: `pe_valid` and `last_chunk` are registered one cycle after an issue. This matches the RS, whose output data registers one cycle after `start_idx`.
- Example, `fire` sampled at edge t with `fv_num` = 8, `MULT_PER_PE` = 2, `pe_ready` held at 1:
  - ISSUE during t+1..t+4 with `start_idx` 0, 2, 4, 6.
  - `pe_valid` during t+2..t+5.
  - `last_chunk` during t+5 (the DRAIN cycle).
  - `complete` during t+6.
  - WAIT_BUF from t+7.
- `busy` is combinational from the state register: high from t+1 until the first IDLE cycle.
- Peak throughput is one chunk per cycle. `pe_ready` = 0 inserts bubbles and `pe_valid` is low the following cycle.
- `Vertex_buf_idle` is sampled only in WAIT_BUF, so the minimum WAIT_BUF dwell is one cycle.

## Structure
- Shared package `GNN_pkg` holds:
  - the state enum `vfs_state_t` (IDLE, ISSUE, DRAIN, CMPL, WAIT_BUF), 3-bit;
  - the global defines `Max_FV_num`, `Mult_per_PE` and `Num_Edge_PE`, used as the parameter defaults at instantiation.
- Single flat module; no sub-module is warranted. Contents:
  - one `always_ff` with asynchronous reset for the state, `start_idx`, `fv_eff`, `pe_valid`, `last_chunk` and `seq_err`;
  - one `always_comb` for next-state logic.

## Test plan
- Basic batch: reset, then `fire` with `fv_num` = 8 and `pe_ready` = 1. Required: `start_idx` 0, 2, 4, 6 on consecutive cycles; four `pe_valid` pulses, the last with `last_chunk` = 1; `complete` exactly 2 cycles after the last issue. Then hold `Vertex_buf_idle` = 0 for 5 cycles and raise it: `busy` drops the cycle after.
- Back-pressure: `fv_num` = 6 with `pe_ready` toggling 1, 0, 0, 1, 1. Required: `start_idx` holds at 2 during the stall; exactly three `pe_valid` pulses in total.
- Illegal counts:
  - `fv_num` = 0: one chunk issued, `seq_err` = 1.
  - `fv_num` = 20 with `MAX_FV_NUM` = 16: eight chunks issued, last `start_idx` = 14, `seq_err` = 1.
  - `fv_num` = 5: three chunks issued.
- `fire` during ISSUE: batch unaffected, `seq_err` rises the next cycle and stays high until reset.
- Async reset mid-batch: assert `reset` between clock edges while `start_idx` = 4. Required: all outputs 0 before the next edge; after release, a new `fire` starts at `start_idx` = 0.
- Max size: `fv_num` = 16. Required: eight issues, no wrap of `start_idx`, `complete` pulse exactly one cycle wide.
